shift_sequencer: RTL and testbench
==================================

# shift_sequencer

Parametrised multi-cycle shift engine in the shared component library. It generalises the plain load/shift register with selectable fill modes (logical, serial-in, rotate, arithmetic) and a programmable shift count. It runs one shift per clock under a start/busy/done handshake and exposes the last shifted-out bit. Datapath controllers use it for bit-serial multiply/divide steps and parallel-to-serial conversion.

## Interface
- WIDTH, 8, data width in bits; must be ≥ 2.
- AW, $clog2(WIDTH+1), width of the shift-count input (derived; do not override).

- clock  input  1  rising-edge clock for all state.
- clear  input  1  synchronous, active-high reset; sampled only on the rising edge of clock.
- D  input  WIDTH  parallel load data.
- load  input  1  parallel load request; accepted only when not busy.
- start  input  1  begin a shift sequence; accepted only when not busy.
- amt  input  AW  number of single-bit shifts; sampled with start.
- left  input  1  direction: 1 = toward MSB, 0 = toward LSB; sampled with start.
- mode  input  2  fill mode: 00 logical (fill 0), 01 serial (fill sin), 10 rotate, 11 arithmetic; sampled with start.
- sin  input  1  serial fill bit; sampled live on every shift cycle.
- Q  output  WIDTH  register contents.
- sout  output  1  bit most recently shifted out of Q.
- busy  output  1  high while shifts are pending.
- done  output  1  one-cycle pulse after the final shift.
- remaining  output  AW  shifts still to perform.

## Operation
- States: IDLE, SHIFT, DONE. clear forces IDLE and sets Q=0, sout=0, busy=0, done=0, remaining=0. clear has priority over every other input.
- IDLE and DONE accept commands identically:
  - load=1 sets Q<=D.
  - start=1 latches left and mode, and sets remaining<=min(amt, WIDTH).
  - Next state is SHIFT if the clamped amt > 0, else DONE.
  - load and start in the same cycle: Q<=D, and the sequence then shifts the newly loaded value.
  - With neither asserted: DONE→IDLE; IDLE stays.
- SHIFT: every cycle performs one shift, sets sout to the bit shifted out, and decrements remaining. When remaining==1 at the edge, the next state is DONE. load and start are ignored.
- Shift rules (left / right):
  - Logical: fill 0 at LSB / fill 0 at MSB.
  - Serial: fill sin at LSB / fill sin at MSB.
  - Rotate: the MSB wraps to the LSB / the LSB wraps to the MSB.
  - Arithmetic: left is identical to logical; right replicates the MSB.
- amt > WIDTH clamps to WIDTH, so WIDTH bits maximum. amt=0 with start produces a done pulse with no shift, and Q and sout are unchanged (Q still takes D if load is also asserted).
- Q and sout change only on load or on a shift.

## Timing
- All outputs are registered. Reset values: Q=0, sout=0, busy=0, done=0, remaining=0.
- Let cycle c be the cycle in which start is sampled high, with clamped count N.
  - busy=1 for cycles c+1 … c+N.
  - Q shows k shifts applied during cycle c+k+1.
  - done=1 only in cycle c+N+1; busy=0 in that cycle.
  - A new start is accepted in cycle c+N+1, giving back-to-back sequences with no idle gap.
- N=0: done=1 in cycle c+1, and busy never rises.
- remaining=N in cycle c+1, decrements each cycle, and reads 0 when done=1.
- clear asserted in any cycle, including mid-SHIFT: the next cycle shows reset values, and no done pulse occurs.
- load or start while busy=1 is dropped, not queued.

## Test plan
- Reset: assert clear for 1 cycle with arbitrary inputs → Q=0x00, sout=0, busy=0, done=0, remaining=0.
- WIDTH=8: load D=0xB4, then start amt=3, left=1, mode=00 → busy for 3 cycles, Q sequence 0x68, 0xD0, 0xA0, sout=1, done pulse in cycle c+4.
- load+start together with D=0x96, amt=2, left=0, mode=11 → Q sequence 0xCB then 0xE5, sout=1. Then load 0x5A with rotate-right amt=8 → Q=0x5A after 8 shifts, done in cycle c+9.
- Q=0x00, start amt=4, left=0, mode=01, sin=1 → Q=0xF0. Also amt=12, mode=00, left=1 on 0xFF → clamps to 8 shifts (busy 8 cycles), Q=0x00.
- start amt=0 → done=1 in cycle c+1, busy stays 0, Q unchanged. A second start issued in that done cycle is accepted.
- Mid-sequence: start amt=6, assert start/load with new data in cycle c+2 → ignored and sequence unaffected. Assert clear in cycle c+3 → next cycle shows Q=0, busy=0, remaining=0, and done never pulses.

Source files
------------

// File: rtl/shift_sequencer_if.sv
// Command/status bundle for shift_sequencer: load/start command side in, register view out.
interface shift_sequencer_if #(
  parameter int WIDTH = 8
);
  localparam int AW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] D;
  logic             load;
  logic             start;
  logic [AW-1:0]    amt;
  logic             left;
  logic [1:0]       mode;
  logic             sin;
  logic [WIDTH-1:0] Q;
  logic             sout;
  logic             busy;
  logic             done;
  logic [AW-1:0]    remaining;

  modport master (
    output D, load, start, amt, left, mode, sin,
    input  Q, sout, busy, done, remaining
  );

  modport slave (
    input  D, load, start, amt, left, mode, sin,
    output Q, sout, busy, done, remaining
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle shift engine: one single-bit shift per clock, selectable fill mode,
// clamped shift count, start/busy/done handshake and last shifted-out bit.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(WIDTH + 1)
) (
  input  logic              i_clock,
  input  logic              i_clear,
  shift_sequencer_if.slave  io
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_LOGIC  = 2'b00;
  localparam logic [1:0] MODE_SERIAL = 2'b01;
  localparam logic [1:0] MODE_ROTATE = 2'b10;
  localparam logic [1:0] MODE_ARITH  = 2'b11;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic             r_sout, w_sout_nxt;
  logic [AW-1:0]    r_rem, w_rem_nxt;
  logic             r_left, w_left_nxt;
  logic [1:0]       r_mode, w_mode_nxt;
  logic             r_busy;
  logic             r_done;

  logic [AW-1:0]    w_amt_clamp;
  logic [WIDTH-1:0] w_shifted;
  logic             w_out_bit;
  logic             w_fill;

  assign w_amt_clamp = (io.amt > AW'(WIDTH)) ? AW'(WIDTH) : io.amt;

  // One-bit shift of the current register using the direction/mode latched at start.
  always_comb begin
    w_fill    = 1'b0;
    w_out_bit = 1'b0;
    w_shifted = r_q;
    if (r_left) begin
      w_out_bit = r_q[WIDTH-1];
      case (r_mode)
        MODE_SERIAL: w_fill = io.sin;
        MODE_ROTATE: w_fill = r_q[WIDTH-1];
        default:     w_fill = 1'b0;
      endcase
      w_shifted = {r_q[WIDTH-2:0], w_fill};
    end else begin
      w_out_bit = r_q[0];
      case (r_mode)
        MODE_SERIAL: w_fill = io.sin;
        MODE_ROTATE: w_fill = r_q[0];
        MODE_ARITH:  w_fill = r_q[WIDTH-1];
        default:     w_fill = 1'b0;
      endcase
      w_shifted = {w_fill, r_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_sout_nxt  = r_sout;
    w_rem_nxt   = r_rem;
    w_left_nxt  = r_left;
    w_mode_nxt  = r_mode;
    case (r_state)
      S_SHIFT: begin
        w_q_nxt    = w_shifted;
        w_sout_nxt = w_out_bit;
        w_rem_nxt  = r_rem - AW'(1);
        if (r_rem == AW'(1)) w_state_nxt = S_DONE;
      end
      default: begin
        // IDLE and DONE take commands the same way, so a new start can follow done directly.
        if (io.load) w_q_nxt = io.D;
        if (io.start) begin
          w_left_nxt  = io.left;
          w_mode_nxt  = io.mode;
          w_rem_nxt   = w_amt_clamp;
          w_state_nxt = (w_amt_clamp != '0) ? S_SHIFT : S_DONE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_state <= S_IDLE;
      r_q     <= '0;
      r_sout  <= 1'b0;
      r_rem   <= '0;
      r_left  <= 1'b0;
      r_mode  <= MODE_LOGIC;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_sout  <= w_sout_nxt;
      r_rem   <= w_rem_nxt;
      r_left  <= w_left_nxt;
      r_mode  <= w_mode_nxt;
      r_busy  <= (w_state_nxt == S_SHIFT);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign io.Q         = r_q;
  assign io.sout      = r_sout;
  assign io.busy      = r_busy;
  assign io.done      = r_done;
  assign io.remaining = r_rem;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized scoreboard bench for shift_sequencer with an arithmetic reference model.
module tb_shift_sequencer;
  localparam int W = 8;
  localparam int M = 'hFF;

  logic clk = 1'b0;
  logic clear;
  always #5 clk = ~clk;

  shift_sequencer_if #(.WIDTH(W)) bus();
  shift_sequencer #(.WIDTH(W)) dut (.i_clock(clk), .i_clear(clear), .io(bus));

  typedef struct {int q; int sout; int n;} exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int m_q = 0;
  int m_sout = 0;
  int bcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Register value and last-out bit after n shifts, computed with whole-word arithmetic.
  function automatic void model(input int q, input int so_in, input int n, input int lft,
                                input int mode, input logic [15:0] sv,
                                output int qo, output int so);
    int s_l, s_r;
    s_l = 0;
    s_r = 0;
    if (n == 0) begin
      qo = q;
      so = so_in;
      return;
    end
    for (int k = 0; k < n; k++) begin
      s_l = (s_l << 1) | int'(sv[k]);
      s_r = s_r | (int'(sv[k]) << k);
    end
    if (lft != 0) begin
      so = (q >> (W - n)) & 1;
      case (mode)
        1:       qo = ((q << n) | s_l) & M;
        2:       qo = ((q << n) | (q >> (W - n))) & M;
        default: qo = (q << n) & M;
      endcase
    end else begin
      so = (q >> (n - 1)) & 1;
      case (mode)
        1:       qo = ((q >> n) | (s_r << (W - n))) & M;
        2:       qo = ((q >> n) | (q << (W - n))) & M;
        3:       qo = (((q >> 7) & 1) != 0) ? ((q >> n) | (M & ~(M >> n))) : (q >> n);
        default: qo = q >> n;
      endcase
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int d);
    bus.D = d[7:0];
    bus.load = 1'b1;
    bus.start = 1'b0;
    cyc();
    bus.load = 1'b0;
    m_q = d & M;
    chk("load_q", bus.Q, m_q);
  endtask

  task automatic run_seq(input bit ld, input int d, input int amt, input bit lft,
                         input int mode, input logic [15:0] sv);
    int n, q0, s0, eq, es;
    exp_t e;
    n = (amt > W) ? W : amt;
    if (ld) m_q = d & M;
    q0 = m_q;
    s0 = m_sout;
    model(q0, s0, n, int'(lft), mode, sv, eq, es);
    e.q = eq; e.sout = es; e.n = n;
    sb.push_back(e);
    bus.load = ld; bus.D = d[7:0]; bus.start = 1'b1; bus.amt = amt[3:0];
    bus.left = lft; bus.mode = mode[1:0]; bus.sin = 1'($urandom_range(0, 1));
    cyc();
    for (int k = 0; k <= n; k++) begin
      model(q0, s0, k, int'(lft), mode, sv, eq, es);
      chk("step_q", bus.Q, eq);
      chk("step_sout", bus.sout, es);
      chk("step_rem", bus.remaining, n - k);
      chk("step_busy", bus.busy, (k < n));
      if (k < n) begin
        // Commands while busy must be dropped.
        bus.sin = sv[k];
        bus.load = 1'($urandom_range(0, 1));
        bus.start = 1'($urandom_range(0, 1));
        bus.D = 8'($urandom);
        bus.amt = 4'($urandom);
        cyc();
      end
    end
    bus.load = 1'b0;
    bus.start = 1'b0;
    m_q = eq;
    m_sout = es;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (clear) begin
      bcnt = 0;
    end else begin
      if (bus.busy) bcnt++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_done: got done=1, want no pending sequence");
        end else begin
          e = sb.pop_front();
          chk("sb_q", bus.Q, e.q);
          chk("sb_sout", bus.sout, e.sout);
          chk("sb_busy_cycles", bcnt, e.n);
          chk("sb_busy_at_done", bus.busy, 0);
          chk("sb_rem_at_done", bus.remaining, 0);
        end
        bcnt = 0;
      end else if (!bus.busy) begin
        bcnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1;
    bus.D = 8'($urandom); bus.load = 1'b1; bus.start = 1'b1; bus.amt = 4'd5;
    bus.left = 1'b1; bus.mode = 2'b10; bus.sin = 1'b1;
    cyc();
    chk("rst_q", bus.Q, 0);
    chk("rst_sout", bus.sout, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_rem", bus.remaining, 0);
    bus.load = 1'b0; bus.start = 1'b0;
    clear = 1'b0;
    cyc();

    do_load('hB4);
    run_seq(1'b0, 0, 3, 1'b1, 0, 16'h0);
    chk("tp_b4_q", bus.Q, 'hA0);
    chk("tp_b4_sout", bus.sout, 1);

    run_seq(1'b1, 'h96, 2, 1'b0, 3, 16'h0);
    chk("tp_96_q", bus.Q, 'hE5);
    chk("tp_96_sout", bus.sout, 1);
    run_seq(1'b1, 'h5A, 8, 1'b0, 2, 16'h0);
    chk("tp_rot_q", bus.Q, 'h5A);

    do_load(0);
    run_seq(1'b0, 0, 4, 1'b0, 1, 16'hFFFF);
    chk("tp_serial_q", bus.Q, 'hF0);
    do_load('hFF);
    run_seq(1'b0, 0, 12, 1'b1, 0, 16'h0);
    chk("tp_clamp_q", bus.Q, 0);

    do_load('h3B);
    run_seq(1'b0, 0, 0, 1'b1, 2, 16'h0);
    chk("tp_amt0_q", bus.Q, 'h3B);
    run_seq(1'b0, 0, 3, 1'b1, 2, 16'h0);
    chk("tp_b2b_q", bus.Q, 'hD9);

    // Mid-sequence commands are ignored; clear aborts without a done pulse.
    do_load('h3C);
    bus.start = 1'b1; bus.amt = 4'd6; bus.left = 1'b1; bus.mode = 2'b00;
    cyc();
    bus.start = 1'b0;
    cyc();
    bus.load = 1'b1; bus.D = 8'hFF; bus.start = 1'b1; bus.amt = 4'd1;
    cyc();
    bus.load = 1'b0; bus.start = 1'b0;
    chk("mid_q", bus.Q, 'hF0);
    chk("mid_rem", bus.remaining, 4);
    chk("mid_busy", bus.busy, 1);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    chk("clr_q", bus.Q, 0);
    chk("clr_sout", bus.sout, 0);
    chk("clr_busy", bus.busy, 0);
    chk("clr_rem", bus.remaining, 0);
    chk("clr_done", bus.done, 0);
    m_q = 0;
    m_sout = 0;
    repeat (8) cyc();

    repeat (40) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) cyc();
      run_seq(1'($urandom_range(0, 1)), int'($urandom), $urandom_range(0, 15),
              1'($urandom_range(0, 1)), $urandom_range(0, 3), 16'($urandom));
    end

    repeat (3) cyc();
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
